mem_scrubber: RTL and testbench

MEM_SCRUBBER -- requirements
Module: mem_scrubber

---
 rtl/mem_scrubber.sv | 155 +++++++++++++++
 tb/tb_mem_scrubber.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_scrubber.sv
// Memory scrubber: walks addresses 0..DEPTH_MEM-1, compares each word to (addr ^ SEED) and writes it back.
// Build option MEM_SCRUB_CORRECT_EN: write back the golden value instead of the read data.
module mem_scrubber #(
    parameter int unsigned WID_MEM   = 18,
    parameter int unsigned DEPTH_MEM = 1024,
    parameter logic [31:0] SEED      = 32'h0,
    parameter logic [31:0] PARK_ADDR = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic [31:0]        raddr,
    input  logic [WID_MEM-1:0] dout,
    output logic [31:0]        waddr,
    output logic [WID_MEM-1:0] din,
    output logic               busy,
    output logic               done,
    output logic [15:0]        err_count,
    output logic [31:0]        first_err_addr,
    output logic               first_err_valid
);

    localparam int unsigned AW        = 32;
    localparam int unsigned CW        = 16;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_MEM - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [WID_MEM-1:0] golden(input logic [AW-1:0] a);
        return WID_MEM'(a ^ SEED);
    endfunction

    state_e              state_q, state_d;
    logic [AW-1:0]       raddr_q, raddr_d;
    logic                cmp_valid_q, cmp_valid_d;
    logic [AW-1:0]       cmp_addr_q, cmp_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CW-1:0]       err_count_q, err_count_d;
    logic [AW-1:0]       first_err_addr_q, first_err_addr_d;
    logic                first_err_valid_q, first_err_valid_d;

    logic                cmp_fire_c;
    logic                mismatch_c;
    logic [WID_MEM-1:0]  wdata_c;

    // A pending compare is dropped (no count, no write) when abort or reset arrives with it.
    assign cmp_fire_c = cmp_valid_q && !abort && !reset;
    assign mismatch_c = cmp_fire_c && (dout != golden(cmp_addr_q));

`ifdef MEM_SCRUB_CORRECT_EN
    assign wdata_c = golden(cmp_addr_q);
`else
    assign wdata_c = dout;
`endif

    always_comb begin
        state_d           = state_q;
        raddr_d           = '0;
        cmp_valid_d       = 1'b0;
        cmp_addr_d        = cmp_addr_q;
        err_count_d       = err_count_q;
        first_err_addr_d  = first_err_addr_q;
        first_err_valid_d = first_err_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d           = ST_SCAN;
                    err_count_d       = '0;
                    first_err_addr_d  = '0;
                    first_err_valid_d = 1'b0;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    cmp_valid_d = 1'b1;
                    cmp_addr_d  = raddr_q;
                    if (raddr_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end else begin
                        raddr_d = raddr_q + AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                state_d = abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Error bookkeeping for the word in the compare stage.
        if (mismatch_c) begin
            if (err_count_q != CNT_MAX) begin
                err_count_d = err_count_q + CW'(1);
            end
            if (!first_err_valid_q) begin
                first_err_valid_d = 1'b1;
                first_err_addr_d  = cmp_addr_q;
            end
        end

        busy_d = (state_d == ST_SCAN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            raddr_q           <= '0;
            cmp_valid_q       <= 1'b0;
            cmp_addr_q        <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            err_count_q       <= '0;
            first_err_addr_q  <= '0;
            first_err_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            raddr_q           <= raddr_d;
            cmp_valid_q       <= cmp_valid_d;
            cmp_addr_q        <= cmp_addr_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            err_count_q       <= err_count_d;
            first_err_addr_q  <= first_err_addr_d;
            first_err_valid_q <= first_err_valid_d;
        end
    end

    // Write port follows the compare stage; read data is only available in that cycle.
    assign waddr           = cmp_fire_c ? cmp_addr_q : PARK_ADDR;
    assign din             = cmp_fire_c ? wdata_c : '0;
    assign raddr           = raddr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err_count       = err_count_q;
    assign first_err_addr  = first_err_addr_q;
    assign first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_mem_scrubber.sv
// Bench for mem_scrubber: behavioural memory plus snapshot-based reference of the expected scan outcome.
module tb_mem_scrubber;

    localparam int unsigned WID  = 18;
    localparam int unsigned N    = 1024;
    localparam int unsigned AW   = 10;
    localparam logic [31:0] SEED = 32'h0001_3C5A;
    localparam logic [31:0] PARK = 32'hFFFF_FFFF;
`ifdef MEM_SCRUB_CORRECT_EN
    localparam bit CORRECT = 1'b1;
`else
    localparam bit CORRECT = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            start;
    logic            abort;
    logic [31:0]     raddr;
    logic [WID-1:0]  dout;
    logic [31:0]     waddr;
    logic [WID-1:0]  din;
    logic            busy;
    logic            done;
    logic [15:0]     err_count;
    logic [31:0]     first_err_addr;
    logic            first_err_valid;

    mem_scrubber #(
        .WID_MEM   (WID),
        .DEPTH_MEM (N),
        .SEED      (SEED),
        .PARK_ADDR (PARK)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .raddr           (raddr),
        .dout            (dout),
        .waddr           (waddr),
        .din             (din),
        .busy            (busy),
        .done            (done),
        .err_count       (err_count),
        .first_err_addr  (first_err_addr),
        .first_err_valid (first_err_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WID-1:0] golden(input int unsigned a);
        logic [31:0] x;
        x = 32'(a) ^ SEED;
        return x[WID-1:0];
    endfunction

    // Memory with registered read, write on every edge, and a backdoor for preload/corruption.
    logic [WID-1:0] mem [N];
    logic [1:0]     bd_op;
    logic [AW-1:0]  bd_addr;
    logic [WID-1:0] bd_mask;
    int             wr_cnt;

    initial wr_cnt = 0;

    always @(posedge clk) begin
        if (bd_op == 2'd1) begin
            for (int unsigned a = 0; a < N; a++) mem[AW'(a)] <= golden(a);
        end else if (bd_op == 2'd2) begin
            mem[bd_addr] <= mem[bd_addr] ^ bd_mask;
        end else if (waddr < 32'(N)) begin
            mem[waddr[AW-1:0]] <= din;
            wr_cnt <= wr_cnt + 1;
        end
        dout <= (raddr < 32'(N)) ? mem[raddr[AW-1:0]] : '0;
    end

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference state: memory image at scan start and the outcome the scan rules imply.
    logic [WID-1:0] snap [N];
    int exp_err;
    int exp_first;
    int snap_bad;

    task automatic take_snapshot();
        exp_err   = 0;
        exp_first = -1;
        for (int a = 0; a < int'(N); a++) begin
            snap[a] = mem[a];
            if (mem[a] !== golden(a)) begin
                exp_err++;
                if (exp_first < 0) exp_first = a;
            end
        end
        snap_bad = exp_err;
        if (exp_err > 65535) exp_err = 65535;
    endtask

    function automatic int count_bad();
        int c;
        c = 0;
        for (int a = 0; a < int'(N); a++) if (mem[a] !== golden(a)) c++;
        return c;
    endfunction

    task automatic fill_golden();
        bd_op = 2'd1;
        tick();
        bd_op = 2'd0;
    endtask

    task automatic flip(input int a);
        bd_addr = AW'(a);
        bd_mask = WID'($urandom_range(1, (1 << WID) - 1));
        bd_op   = 2'd2;
        tick();
        bd_op   = 2'd0;
    endtask

    int seq_bad;
    int done_cnt;
    int done_at;
    int wr_base;

    // One scan from a start pulse; optional abort, re-start or reset at a given scan cycle (k=1 is first SCAN cycle).
    task automatic run_scan(input int abort_at, input int restart_at, input int reset_at);
        bit             live;
        logic [31:0]    er;
        logic [31:0]    ew;
        logic [WID-1:0] ed;
        bit             eb;
        int             pe;
        int             pf;
        take_snapshot();
        seq_bad  = 0;
        done_cnt = 0;
        done_at  = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= int'(N) + 4; k++) begin
            live = !((abort_at > 0 && k > abort_at) || (reset_at > 0 && k > reset_at));
            if (live) begin
                er = (k <= int'(N)) ? 32'(k - 1) : 32'd0;
                ew = (k >= 2 && k <= int'(N) + 1) ? 32'(k - 2) : PARK;
                ed = '0;
                if (k >= 2 && k <= int'(N) + 1) ed = CORRECT ? golden(k - 2) : snap[k - 2];
                eb = (k >= 1 && k <= int'(N) + 1);
                if (raddr !== er || waddr !== ew || din !== ed || busy !== eb) seq_bad++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (abort_at > 0 && k == abort_at + 1) begin
                // Addresses compared before the abort cycle are 0..abort_at-3.
                pe = 0;
                pf = -1;
                for (int a = 0; a <= abort_at - 3; a++) begin
                    if (snap[a] !== golden(a)) begin
                        pe++;
                        if (pf < 0) pf = a;
                    end
                end
                check("abort_busy", 64'(busy), 64'(0));
                check("abort_raddr", 64'(raddr), 64'(0));
                check("abort_waddr", 64'(waddr), 64'(PARK));
                check("abort_err", 64'(err_count), 64'(pe));
                check("abort_first", 64'(first_err_addr), (pf < 0) ? 64'(0) : 64'(pf));
                check("abort_fvalid", 64'(first_err_valid), 64'(pf >= 0));
            end
            if (reset_at > 0 && k == reset_at + 1) begin
                check("rst_raddr", 64'(raddr), 64'(0));
                check("rst_waddr", 64'(waddr), 64'(PARK));
                check("rst_din", 64'(din), 64'(0));
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_done", 64'(done), 64'(0));
                check("rst_err", 64'(err_count), 64'(0));
                check("rst_first", 64'(first_err_addr), 64'(0));
                check("rst_fvalid", 64'(first_err_valid), 64'(0));
            end
            abort = (k == abort_at);
            start = (k == restart_at);
            reset = (k == reset_at);
            if (k == reset_at) wr_base = wr_cnt;
            tick();
        end
        abort = 1'b0;
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic check_full_scan(input string tag);
        check({tag, "_seq"}, 64'(seq_bad), 64'(0));
        check({tag, "_done_at"}, 64'(done_at), 64'(N + 2));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
        check({tag, "_err"}, 64'(err_count), 64'(exp_err));
        check({tag, "_first"}, 64'(first_err_addr), (exp_first < 0) ? 64'(0) : 64'(exp_first));
        check({tag, "_fvalid"}, 64'(first_err_valid), 64'(exp_first >= 0));
        check({tag, "_mem"}, 64'(count_bad()), CORRECT ? 64'(0) : 64'(snap_bad));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        bd_op    = 2'd0;
        bd_addr  = '0;
        bd_mask  = '0;
        wr_base  = 0;
        repeat (3) tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        check("reset_raddr", 64'(raddr), 64'(0));
        check("reset_waddr", 64'(waddr), 64'(PARK));
        check("reset_din", 64'(din), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_err", 64'(err_count), 64'(0));
        check("reset_first", 64'(first_err_addr), 64'(0));
        check("reset_fvalid", 64'(first_err_valid), 64'(0));
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tick();

        // Clean memory.
        fill_golden();
        run_scan(-1, -1, -1);
        check_full_scan("clean");
        check("clean_idle_busy", 64'(busy), 64'(0));

        // Two corrupted words, then a second scan over the result.
        flip(5);
        flip(1000);
        run_scan(-1, -1, -1);
        check_full_scan("two_err");
        check("two_err_count", 64'(err_count), 64'(2));
        run_scan(-1, -1, -1);
        check_full_scan("rescan");
        check("rescan_count", 64'(err_count), CORRECT ? 64'(0) : 64'(2));
        check("rescan_w5", 64'(mem[5] !== golden(5)), 64'(!CORRECT));
        check("rescan_w1000", 64'(mem[1000] !== golden(1000)), 64'(!CORRECT));

        // Random corruption patterns.
        for (int it = 0; it < 3; it++) begin
            fill_golden();
            for (int j = 0; j < int'($urandom_range(1, 6)); j++) flip(int'($urandom_range(0, N - 1)));
            run_scan(-1, -1, -1);
            check_full_scan("rand");
        end

        // Abort 10 cycles into the scan.
        fill_golden();
        flip(3);
        run_scan(10, -1, -1);
        check("abort_no_done", 64'(done_cnt), 64'(0));
        check("abort_hold_err", 64'(err_count), 64'(1));
        check("abort_hold_first", 64'(first_err_addr), 64'(3));

        // Start and abort together in IDLE.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy0", 64'(busy), 64'(0));
        tick();
        check("start_abort_busy1", 64'(busy), 64'(0));
        check("start_abort_raddr", 64'(raddr), 64'(0));

        // Re-pulse start mid-scan.
        fill_golden();
        flip(700);
        run_scan(-1, 500, -1);
        check_full_scan("restart");

        // Reset mid-scan with a counted error before it.
        fill_golden();
        flip(7);
        run_scan(-1, -1, 300);
        check("rst_no_done", 64'(done_cnt), 64'(0));
        check("rst_no_writes", 64'(wr_cnt - wr_base), 64'(0));
        check("rst_idle_busy", 64'(busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
